// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencer, single-outstanding memory request FSM and instruction FIFO.
// Optional macro FETCH_MISALIGN_CHECK_EN flags misaligned redirects and halts fetch.
module instr_fetch_unit #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
    input  logic                  i_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [6:0]            o_op_code,
    output logic [4:0]            o_rd,
    output logic [2:0]            o_funct3,
    output logic [4:0]            o_rs1,
    output logic [4:0]            o_rs2,
    output logic [6:0]            o_funct7,
    output logic                  o_misalign_err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
    logic                  err_q, err_d;
    logic                  run_q;
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] redir_pc;
    logic                  misalign;
    logic                  fire, push, pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir_pc = i_redirect_pc;
    assign misalign = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
`else
    logic unused_redir_lo;
    assign unused_redir_lo = ^i_redirect_pc[1:0];
    assign redir_pc = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign misalign = 1'b0;
`endif

    // run_q keeps the request low during reset and issues the first fetch one cycle after release
    assign o_imem_req_valid = run_q && !err_q && (state_q == S_FETCH) && (cnt_q < CW'(FIFO_DEPTH));
    assign o_imem_addr      = pc_q;
    assign fire             = o_imem_req_valid && i_imem_req_ready;
    assign push             = (state_q == S_WAIT) && i_imem_rsp_valid;
    assign pop              = o_instr_valid && i_instr_ready;

    assign o_instr_valid  = (cnt_q != '0);
    assign o_instr        = fifo_data_q[rd_q];
    assign o_pc           = fifo_pc_q[rd_q];
    assign o_op_code      = o_instr[6:0];
    assign o_rd           = o_instr[11:7];
    assign o_funct3       = o_instr[14:12];
    assign o_rs1          = o_instr[19:15];
    assign o_rs2          = o_instr[24:20];
    assign o_funct7       = o_instr[31:25];
    assign o_misalign_err = err_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        err_d      = err_q || misalign;
        if (i_redirect_valid) begin
            pc_d  = redir_pc;
            cnt_d = '0;
            wr_d  = '0;
            rd_d  = '0;
            // FLUSH only if a response is still owed after this cycle
            state_d = (fire || ((state_q != S_FETCH) && !i_imem_rsp_valid)) ? S_FLUSH : S_FETCH;
        end else begin
            unique case (state_q)
                S_FETCH: if (fire) begin
                    pc_d       = pc_q + ADDR_WIDTH'(4);
                    req_addr_d = pc_q;
                    state_d    = S_WAIT;
                end
                S_WAIT:  if (i_imem_rsp_valid) state_d = S_FETCH;
                S_FLUSH: if (i_imem_rsp_valid) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            err_q      <= 1'b0;
            run_q      <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            err_q      <= err_d;
            run_q      <= 1'b1;
            if (push && !i_redirect_valid) begin
                fifo_pc_q[wr_q]   <= req_addr_q;
                fifo_data_q[wr_q] <= i_imem_rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push expected requests/instructions,
// independent monitors pop and compare whenever the DUT issues a request or hands over an instruction.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready;
    logic [31:0] imem_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, pc;
    logic [6:0]  op_code, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic        misalign;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_addr(imem_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .i_redirect_valid(redir_valid), .i_redirect_pc(redir_pc),
        .o_instr_valid(instr_valid), .i_instr_ready(instr_ready),
        .o_instr(instr), .o_pc(pc),
        .o_op_code(op_code), .o_rd(rd), .o_funct3(funct3), .o_rs1(rs1), .o_rs2(rs2), .o_funct7(funct7),
        .o_misalign_err(misalign)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_req[$];
    logic [63:0] exp_ins[$];
    int          granted = 0;
    int          grant_limit = 0;
    logic [31:0] slow_addr = 32'h1;
    int          slow_lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5013;
    endfunction

    function automatic logic [63:0] ins(input logic [31:0] a);
        return {a, mem_word(a)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: one response per accepted request, slow_lat extra cycles for slow_addr
    initial begin : mem
        logic        fire_s;
        logic [31:0] addr_s;
        logic        pend;
        logic [31:0] pa;
        int          cnt;
        pend = 1'b0; pa = '0; cnt = 0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
        forever begin
            @(negedge clk);
            fire_s = rst_n && req_valid && req_ready;
            addr_s = imem_addr;
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            if (fire_s) begin
                granted++;
                pend = 1'b1;
                pa   = addr_s;
                cnt  = (addr_s == slow_addr) ? slow_lat : 0;
            end
            if (pend) begin
                if (cnt == 0) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_word(pa);
                    pend      = 1'b0;
                end else cnt--;
            end
            req_ready = granted < grant_limit;
        end
    end

    initial begin : req_mon
        forever begin
            @(negedge clk);
            if (rst_n && req_valid && req_ready) begin
                if (exp_req.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected: got addr %0h expected none", imem_addr);
                end else chk("req_addr", {32'h0, imem_addr}, {32'h0, exp_req.pop_front()});
            end
        end
    end

    initial begin : ins_mon
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && instr_valid && instr_ready && !redir_valid) begin
                if (exp_ins.size() == 0) begin
                    total++; bad++;
                    $display("FAIL ins_unexpected: got pc %0h expected none", pc);
                end else begin
                    e = exp_ins.pop_front();
                    chk("ins_pc_word", {pc, instr}, e);
                    chk("ins_fields", {32'h0, funct7, rs2, rs1, funct3, rd, op_code}, {32'h0, e[31:0]});
                end
            end
        end
    end

    task automatic align();
        @(posedge clk); #1;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic allow(input int n);
        @(negedge clk); #1;
        grant_limit = granted + n;
        align();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redir_valid = 1'b0;
        #1;
        chk("rst_req_valid", {63'h0, req_valid}, 64'h0);
        chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_misalign", {63'h0, misalign}, 64'h0);
        cyc(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string name, input logic [31:0] a);
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (req_valid && req_ready && imem_addr == a) found = 1'b1;
        end
        chk(name, {63'h0, found}, 64'h1);
        align();
    endtask

    task automatic drained(input string name);
        chk({name, "_req_left"}, exp_req.size(), 0);
        chk({name, "_ins_left"}, exp_ins.size(), 0);
        exp_req.delete();
        exp_ins.delete();
    endtask

    initial begin
        redir_valid = 1'b0; redir_pc = '0; instr_ready = 1'b1;
        cyc(2);

        // Reset release, back-to-back fetch of 0x0, 0x4, 0x8
        instr_ready = 1'b1;
        allow(3);
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_ins = '{ins(32'h0), ins(32'h4), ins(32'h8)};
        do_reset();
        cyc(15);
        drained("A");

        // Decoder stalled: FIFO fills, one pop admits exactly one request
        instr_ready = 1'b0;
        allow(3);
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_ins = '{ins(32'h0), ins(32'h4), ins(32'h8)};
        do_reset();
        cyc(8);
        repeat (3) begin @(negedge clk); chk("B_full_noreq", {63'h0, req_valid}, 64'h0); end
        align();
        instr_ready = 1'b1;
        align();
        instr_ready = 1'b0;
        cyc(6);
        repeat (3) begin @(negedge clk); chk("B_refull_noreq", {63'h0, req_valid}, 64'h0); end
        @(negedge clk);
        chk("B_head", {31'h0, instr_valid, pc}, {31'h0, 1'b1, 32'h4});
        align();
        instr_ready = 1'b1;
        cyc(6);
        repeat (3) begin
            @(negedge clk);
            chk("B_hold_addr", {31'h0, req_valid, imem_addr}, {31'h0, 1'b1, 32'hC});
        end
        align();
        drained("B");

        // Redirect to 0x100 while the 0x8 response is outstanding
        instr_ready = 1'b1;
        slow_addr = 32'h8; slow_lat = 3;
        allow(4);
        exp_req = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_ins = '{ins(32'h0), ins(32'h100)};
        do_reset();
        wait_req("C_wait_4", 32'h4);
        instr_ready = 1'b0;
        wait_req("C_wait_8", 32'h8);
        redir_valid = 1'b1; redir_pc = 32'h100;
        @(negedge clk);
        chk("C_valid_at_redir", {63'h0, instr_valid}, 64'h1);
        align();
        redir_valid = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("C_valid_after_redir", {63'h0, instr_valid}, 64'h0);
        align();
        cyc(12);
        slow_addr = 32'h1;
        drained("C");

        // Redirect coincides with a response push and a decoder pop
        instr_ready = 1'b0;
        allow(3);
        exp_req = '{32'h0, 32'h4, 32'h200};
        exp_ins = '{ins(32'h200)};
        do_reset();
        wait_req("D_wait_4", 32'h4);
        instr_ready = 1'b1; redir_valid = 1'b1; redir_pc = 32'h200;
        @(negedge clk);
        chk("D_push_pop_cycle", {62'h0, rsp_valid, instr_valid}, 64'h3);
        align();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("D_empty_after", {63'h0, instr_valid}, 64'h0);
        align();
        cyc(10);
        drained("D");

        // Misaligned redirect target 0x102
        instr_ready = 1'b1;
        allow(0);
        do_reset();
        cyc(3);
        @(negedge clk);
        chk("E_idle_req", {31'h0, req_valid, imem_addr}, {31'h0, 1'b1, 32'h0});
        align();
        redir_valid = 1'b1; redir_pc = 32'h102;
        align();
        redir_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        allow(2);
        repeat (4) begin
            @(negedge clk);
            chk("E_halt", {62'h0, misalign, req_valid}, 64'h2);
        end
        align();
`else
        exp_req = '{32'h100, 32'h104};
        exp_ins = '{ins(32'h100), ins(32'h104)};
        allow(2);
        cyc(10);
        @(negedge clk);
        chk("E_no_err", {63'h0, misalign}, 64'h0);
        align();
`endif
        drained("E");

        // PC wrap from 0xFFFF_FFFC to 0x0
        instr_ready = 1'b1;
        allow(0);
        do_reset();
        cyc(2);
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        align();
        redir_valid = 1'b0;
        exp_req = '{32'hFFFF_FFFC, 32'h0};
        exp_ins = '{ins(32'hFFFF_FFFC), ins(32'h0)};
        allow(2);
        cyc(10);
        drained("F");

        // Reset while waiting for a response: the late response lands in FETCH and is ignored
        instr_ready = 1'b1;
        slow_addr = 32'h0; slow_lat = 2;
        allow(2);
        exp_req = '{32'h0, 32'h0};
        exp_ins = '{ins(32'h0)};
        do_reset();
        wait_req("G_wait_0", 32'h0);
        rst_n = 1'b0;
        #1;
        chk("G_async_req", {63'h0, req_valid}, 64'h0);
        align();
        slow_addr = 32'h1;
        rst_n = 1'b1;
        cyc(12);
        drained("G");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, which is the PC and memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, which is the instruction width.
REQ-003 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-004 SHALL have parameter FIFO_DEPTH, default 2, which is the number of instruction buffer entries; legal values are 2 and 4.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock, rising-edge active.
REQ-006 SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port o_imem_req_valid, output, 1 bit: fetch request valid.
REQ-008 SHALL have port i_imem_req_ready, input, 1 bit: the memory accepts the request.
REQ-009 SHALL have port o_imem_addr, output, ADDR_WIDTH bits: the fetch address.
REQ-010 SHALL have port i_imem_rsp_valid, input, 1 bit: read data valid.
REQ-011 SHALL have port i_imem_rsp_data, input, DATA_WIDTH bits: the fetched instruction word.
REQ-012 SHALL have port i_redirect_valid, input, 1 bit: a branch/jump redirect.
REQ-013 SHALL have port i_redirect_pc, input, ADDR_WIDTH bits: the redirect target.
REQ-014 SHALL have port o_instr_valid, output, 1 bit: the FIFO head is valid toward the decoder.
REQ-015 SHALL have port i_instr_ready, input, 1 bit: the decoder consumes the head.
REQ-016 SHALL have ports o_instr (DATA_WIDTH) and o_pc (ADDR_WIDTH), both outputs, carrying the head word and its address.
REQ-017 SHALL have output slices of the head: o_op_code [6:0], o_rd [11:7], o_funct3 [14:12], o_rs1 [19:15], o_rs2 [24:20], o_funct7 [31:25].
REQ-018 SHALL have port o_misalign_err, output, 1 bit: sticky misaligned-redirect flag.

Function
REQ-019 SHALL implement states FETCH, WAIT_RSP and FLUSH, with at most one outstanding request.
REQ-020 SHALL in FETCH assert o_imem_req_valid with o_imem_addr = pc only while the FIFO count < FIFO_DEPTH.
REQ-021 SHALL on req_valid && req_ready advance pc by 4, wrapping modulo 2^ADDR_WIDTH, and go to WAIT_RSP.
REQ-022 SHALL keep o_imem_addr stable while req_valid is high and ready is low; the request may be withdrawn only by a redirect.
REQ-023 SHALL in WAIT_RSP, on i_imem_rsp_valid, push {request address, data} into the FIFO and return to FETCH.
REQ-024 SHALL ignore i_imem_rsp_valid received in FETCH.
REQ-025 SHALL drive o_instr_valid = FIFO non-empty, with all output fields taken combinationally from the head.
REQ-026 SHALL pop the head on o_instr_valid && i_instr_ready; a simultaneous push and pop leaves the count unchanged.
REQ-027 SHALL never overflow the FIFO, since FIFO count plus outstanding requests is at most FIFO_DEPTH.
REQ-028 SHALL on i_redirect_valid take the following actions:
  - load pc from i_redirect_pc;
  - empty the FIFO, so o_instr_valid is low the next cycle;
  - drop any same-cycle push or pop;
  - drop any unaccepted request.
REQ-029 SHALL on a redirect go to FLUSH if a request is outstanding or is accepted in the same cycle, otherwise go to FETCH.
REQ-030 SHALL in FLUSH discard the next response, then go to FETCH; a further redirect while in FLUSH only updates pc.
REQ-031 SHALL give redirect priority over every other same-cycle event.

Reset
REQ-032 SHALL on i_reset_n low, immediately and asynchronously, set:
  - pc = RESET_PC;
  - state = FETCH;
  - FIFO empty;
  - o_imem_req_valid = 0;
  - o_instr_valid = 0;
  - o_misalign_err = 0.
REQ-033 SHALL treat reset during WAIT_RSP or FLUSH as discarding the outstanding response; the first post-reset request issues the cycle after deassertion.

Configuration
REQ-034 SHALL use macro FETCH_MISALIGN_CHECK_EN to control misaligned-redirect handling.
  - Defined: a redirect with i_redirect_pc[1:0] != 0 sets o_misalign_err, which stays set until reset, and fetch halts (no further requests).
  - Undefined: i_redirect_pc[1:0] is forced to 0, and o_misalign_err is tied to 0.

Verification
REQ-035 SHALL cover reset release with ready=1 and a 1-cycle response: addresses 0x0, 0x4, 0x8 are issued, and the instruction with o_pc=0x0 appears first.
REQ-036 SHALL cover i_instr_ready=0 with FIFO_DEPTH=2: after two pushes req_valid stays 0, and after one pop exactly one new request issues.
REQ-037 SHALL cover a redirect to 0x100 while WAIT_RSP for 0x8: the 0x8 response is discarded, the next request address is 0x100, and o_instr_valid goes low one cycle after the redirect.
REQ-038 SHALL cover a redirect in the same cycle as a response push and a decoder pop: the FIFO ends empty and no 0x-stale o_pc is ever presented.
REQ-039 SHALL cover a redirect to 0x102:
  - with the macro defined: o_misalign_err=1 and no further requests;
  - without the macro: the request address is 0x100.
REQ-040 SHALL cover pc = 0xFFFF_FFFC: the next request address wraps to 0x0.
